cms_multi_range_trace_gate: RTL and testbench

- Parameterised successor to the single-range trace monitor.
- Filters the committed-instruction stream (pc, instr) against NUM_RANGES independently enabled address windows, start/end trace triggers and a WFI stop.
- Buffers accepted packets in an internal FIFO and emits them on an AXI-Stream master with interval/WFI tlast.
- Counts packets lost to back-pressure; sits between the core trace port and the DMA FIFO.

---
 rtl/cms_multi_range_trace_gate.sv | 151 +++++++++++++++
 tb/tb_cms_multi_range_trace_gate.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cms_multi_range_trace_gate.sv
// Multi-range trace gate: filters the committed-instruction stream against
// NUM_RANGES address windows, start/end triggers and a WFI stop, buffers the
// accepted {pc, instr} packets and streams them out on an AXI-Stream master.
module cms_multi_range_trace_gate #(
  parameter int XLEN            = 64,
  parameter int INSTR_WIDTH     = 32,
  parameter int NUM_RANGES      = 4,
  parameter int FIFO_DEPTH      = 16,
  parameter int CTRL_DATA_WIDTH = 64,
  parameter logic [INSTR_WIDTH-1:0] WFI_INSTRUCTION = 32'h10500073
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [INSTR_WIDTH-1:0]          instr,
  input  logic [XLEN-1:0]                 pc,
  input  logic                            pc_valid,
  output logic                            M_AXIS_tvalid,
  input  logic                            M_AXIS_tready,
  output logic [XLEN+INSTR_WIDTH-1:0]     M_AXIS_tdata,
  output logic                            M_AXIS_tlast,
  input  logic [31:0]                     tlast_interval,
  input  logic [7:0]                      ctrl_addr,
  input  logic [CTRL_DATA_WIDTH-1:0]      ctrl_wdata,
  input  logic                            ctrl_write_enable,
  output logic [31:0]                     dropped_count,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = XLEN + INSTR_WIDTH + 1;
  localparam logic [PW:0] DEPTH_L = (PW+1)'(FIFO_DEPTH);

  // Control / trigger state
  logic                  start_en_q, end_en_q, wfi_reached_q, trace_active_q;
  logic [XLEN-1:0]       start_addr_q, end_addr_q;
  logic [NUM_RANGES-1:0] range_mask_q;
  logic [XLEN-1:0]       lower_q [NUM_RANGES];
  logic [XLEN-1:0]       upper_q [NUM_RANGES];
  logic [31:0]           dropped_q;

  // Packet buffer state; entry = {pc, instr, force_last}
  logic [EW-1:0]         mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [PW:0]           level_q;
  logic [31:0]           beat_q;

  logic in_range, start_hit, end_hit, armed, accept, full, wr_en, rd_en;
  logic is_wfi, ivl_hit;
  logic [EW-1:0] head;
  logic unused_wdata;

  assign unused_wdata = &{1'b0, ctrl_wdata};

  // Window match: an empty mask passes everything; lower>upper never matches
  always_comb begin
    in_range = (range_mask_q == '0);
    for (int i = 0; i < NUM_RANGES; i++) begin
      if (range_mask_q[i] && (pc >= lower_q[i]) && (pc <= upper_q[i]))
        in_range = 1'b1;
    end
  end

  assign is_wfi    = (instr == WFI_INSTRUCTION);
  assign start_hit = pc_valid & start_en_q & (pc == start_addr_q);
  assign end_hit   = pc_valid & end_en_q & (pc == end_addr_q);
  assign armed     = ~start_en_q | trace_active_q | start_hit;
  assign accept    = pc_valid & ~wfi_reached_q & armed & in_range;
  assign full      = (level_q == DEPTH_L);
  assign wr_en     = accept & ~full;
  assign rd_en     = M_AXIS_tvalid & M_AXIS_tready;

  // Output side: head of buffer, interval tlast uses >= so a shrunk interval
  // closes the packet on the very next beat
  assign head          = mem_q[rd_ptr_q];
  assign ivl_hit       = (tlast_interval != 32'd0) && (beat_q >= tlast_interval - 32'd1);
  assign M_AXIS_tvalid = (level_q != '0);
  assign M_AXIS_tdata  = M_AXIS_tvalid ? head[EW-1:1] : '0;
  assign M_AXIS_tlast  = M_AXIS_tvalid & (head[0] | ivl_hit);
  assign fifo_level    = level_q;
  assign dropped_count = dropped_q;

  // Control registers; hardware updates first, a same-cycle ctrl write overrides
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_en_q     <= 1'b0;
      end_en_q       <= 1'b0;
      start_addr_q   <= '0;
      end_addr_q     <= '1;
      wfi_reached_q  <= 1'b0;
      trace_active_q <= 1'b0;
      range_mask_q   <= '0;
      dropped_q      <= '0;
      for (int i = 0; i < NUM_RANGES; i++) begin
        lower_q[i] <= '0;
        upper_q[i] <= '1;
      end
    end else begin
      if (end_hit)
        trace_active_q <= 1'b0;
      else if (start_hit)
        trace_active_q <= 1'b1;
      if (pc_valid && is_wfi)
        wfi_reached_q <= 1'b1;
      if (accept && full && (dropped_q != '1))
        dropped_q <= dropped_q + 32'd1;
      if (ctrl_write_enable) begin
        case (ctrl_addr)
          8'h00: start_en_q    <= ctrl_wdata[0];
          8'h01: end_en_q      <= ctrl_wdata[0];
          8'h02: start_addr_q  <= ctrl_wdata[XLEN-1:0];
          8'h03: end_addr_q    <= ctrl_wdata[XLEN-1:0];
          8'h04: wfi_reached_q <= ctrl_wdata[0];
          8'h05: range_mask_q  <= ctrl_wdata[NUM_RANGES-1:0];
          8'h06: dropped_q     <= '0;
          default: ;
        endcase
        for (int i = 0; i < NUM_RANGES; i++) begin
          if (ctrl_addr == 8'(16 + 2*i)) lower_q[i] <= ctrl_wdata[XLEN-1:0];
          if (ctrl_addr == 8'(17 + 2*i)) upper_q[i] <= ctrl_wdata[XLEN-1:0];
        end
      end
    end
  end

  // Buffer pointers, occupancy and beat counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      beat_q   <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        beat_q   <= M_AXIS_tlast ? 32'd0 : beat_q + 32'd1;
      end
      case ({wr_en, rd_en})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Packet storage (data only, no reset)
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {pc, instr, is_wfi};
  end

endmodule

// File: tb/tb_cms_multi_range_trace_gate.sv
// Bench for cms_multi_range_trace_gate: directed tables/sequences plus a
// randomized run checked every cycle against a queue-based reference model.
module tb_cms_multi_range_trace_gate;

  localparam int XLEN = 64, IW = 32, NR = 4, DEPTH = 16, CW = 64;
  localparam logic [31:0] WFI = 32'h10500073;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [IW-1:0] instr = '0;
  logic [XLEN-1:0] pc = '0;
  logic pc_valid = 1'b0;
  logic tvalid, tlast;
  logic tready = 1'b0;
  logic [XLEN+IW-1:0] tdata;
  logic [31:0] tlast_interval = '0;
  logic [7:0] ctrl_addr = '0;
  logic [CW-1:0] ctrl_wdata = '0;
  logic ctrl_we = 1'b0;
  logic [31:0] dropped;
  logic [4:0] level;

  cms_multi_range_trace_gate dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .pc(pc), .pc_valid(pc_valid),
    .M_AXIS_tvalid(tvalid), .M_AXIS_tready(tready), .M_AXIS_tdata(tdata),
    .M_AXIS_tlast(tlast), .tlast_interval(tlast_interval),
    .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
    .ctrl_write_enable(ctrl_we), .dropped_count(dropped), .fifo_level(level)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct { logic [63:0] pc; logic [31:0] instr; bit f; } pkt_t;
  pkt_t mq[$];
  bit m_sen, m_een, m_wfi, m_act;
  logic [63:0] m_sa, m_ea;
  logic [NR-1:0] m_mask;
  logic [63:0] m_lo[NR], m_hi[NR];
  logic [31:0] m_drop;
  int unsigned m_beat;

  int n_cmp = 0, n_err = 0;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_tlast();
    if (mq.size() == 0) return 1'b0;
    return mq[0].f || (tlast_interval != 0 && m_beat >= tlast_interval - 1);
  endfunction

  task automatic model_step();
    bit hs, tl, sh, eh, armed, inr, acc, full;
    if (!rst_n) begin
      mq.delete();
      m_sen = 0; m_een = 0; m_wfi = 0; m_act = 0;
      m_sa = '0; m_ea = '1; m_mask = '0; m_drop = '0; m_beat = 0;
      for (int i = 0; i < NR; i++) begin m_lo[i] = '0; m_hi[i] = '1; end
      return;
    end
    tl = m_tlast();
    hs = (mq.size() != 0) && tready;
    sh = pc_valid && m_sen && pc == m_sa;
    eh = pc_valid && m_een && pc == m_ea;
    armed = !m_sen || m_act || sh;
    inr = (m_mask == 0);
    for (int i = 0; i < NR; i++)
      if (m_mask[i] && pc >= m_lo[i] && pc <= m_hi[i]) inr = 1;
    acc = pc_valid && !m_wfi && armed && inr;
    full = (mq.size() == DEPTH);
    if (hs) begin
      void'(mq.pop_front());
      m_beat = tl ? 0 : m_beat + 1;
    end
    if (acc) begin
      if (full) begin if (m_drop != 32'hFFFF_FFFF) m_drop++; end
      else mq.push_back('{pc, instr, instr == WFI});
    end
    if (eh) m_act = 0; else if (sh) m_act = 1;
    if (pc_valid && instr == WFI) m_wfi = 1;
    if (ctrl_we) begin
      case (ctrl_addr)
        8'h00: m_sen = ctrl_wdata[0];
        8'h01: m_een = ctrl_wdata[0];
        8'h02: m_sa = ctrl_wdata;
        8'h03: m_ea = ctrl_wdata;
        8'h04: m_wfi = ctrl_wdata[0];
        8'h05: m_mask = ctrl_wdata[NR-1:0];
        8'h06: m_drop = '0;
        default: ;
      endcase
      for (int i = 0; i < NR; i++) begin
        if (ctrl_addr == 8'(16 + 2*i)) m_lo[i] = ctrl_wdata;
        if (ctrl_addr == 8'(17 + 2*i)) m_hi[i] = ctrl_wdata;
      end
    end
  endtask

  // One clock: advance model, let DUT take the edge, compare after the edge
  task automatic step();
    logic [95:0] exp_d;
    model_step();
    @(posedge clk); #1;
    exp_d = (mq.size() != 0) ? {mq[0].pc, mq[0].instr} : 96'd0;
    chk("tvalid", tvalid, mq.size() != 0);
    chk("tdata", tdata, exp_d);
    chk("tlast", tlast, m_tlast());
    chk("fifo_level", level, mq.size());
    chk("dropped_count", dropped, m_drop);
  endtask

  task automatic wr(input logic [7:0] a, input logic [63:0] d);
    ctrl_we = 1; ctrl_addr = a; ctrl_wdata = d; pc_valid = 0;
    step();
    ctrl_we = 0;
  endtask

  task automatic ins(input logic [63:0] p, input logic [31:0] i);
    pc_valid = 1; pc = p; instr = i;
    step();
    pc_valid = 0;
  endtask

  task automatic ins_exp(input logic [63:0] p, input bit e, input string nm);
    ins(p, NOP);
    chk({nm, "_valid"}, tvalid, e);
    if (e) chk({nm, "_pc"}, tdata[95:32], p);
  endtask

  task automatic do_reset();
    rst_n = 0; pc_valid = 0; ctrl_we = 0;
    step(); step();
    rst_n = 1;
  endtask

  typedef struct { logic [63:0] pc; bit emit; } rvec_t;

  initial begin
    rvec_t rv[5];
    rv[0] = '{64'h1FFC, 1'b0};
    rv[1] = '{64'h2000, 1'b1};
    rv[2] = '{64'h20FF, 1'b1};
    rv[3] = '{64'h2100, 1'b0};
    rv[4] = '{64'h8000, 1'b1};

    // Reset state
    do_reset();
    chk("rst_tvalid", tvalid, 0);
    chk("rst_level", level, 0);
    chk("rst_dropped", dropped, 0);
    chk("rst_tdata", tdata, 0);

    // Plain pass-through with interval tlast every 4 beats
    tready = 1; tlast_interval = 4;
    for (int k = 0; k < 4; k++) begin
      ins(64'h1000 + 4*k, 32'hA0 + k);
      chk("pass_valid", tvalid, 1);
      chk("pass_data", tdata, {64'h1000 + 4*k, 32'hA0 + k});
      chk("pass_tlast", tlast, k == 3);
    end
    step();

    // Range windows, table-driven
    do_reset(); tlast_interval = 0;
    wr(8'h10, 64'h2000); wr(8'h11, 64'h20FF);
    wr(8'h14, 64'h8000); wr(8'h15, 64'h8000);
    wr(8'h05, 64'b0101);
    for (int k = 0; k < 5; k++) ins_exp(rv[k].pc, rv[k].emit, "range");
    step();

    // Start/end triggers and re-arm
    do_reset();
    wr(8'h00, 1); wr(8'h01, 1); wr(8'h02, 64'h3000); wr(8'h03, 64'h3008);
    ins_exp(64'h2FFC, 0, "trig"); ins_exp(64'h3000, 1, "trig");
    ins_exp(64'h3004, 1, "trig"); ins_exp(64'h3008, 1, "trig");
    ins_exp(64'h300C, 0, "trig"); ins_exp(64'h3004, 0, "trig");
    ins_exp(64'h3000, 1, "rearm"); ins_exp(64'h3004, 1, "rearm");
    step();

    // Overflow with back-pressure, drop counter clear, drain in order
    do_reset(); tready = 0;
    for (int k = 0; k < 20; k++) ins(64'h4000 + 4*k, NOP);
    chk("ovf_level", level, 16);
    chk("ovf_dropped", dropped, 4);
    wr(8'h06, 0);
    chk("ovf_clear", dropped, 0);
    tready = 1; #1;
    for (int k = 0; k < 16; k++) begin
      chk("drain_pc", tdata[95:32], 64'h4000 + 4*k);
      step();
    end
    chk("drain_empty", tvalid, 0);

    // WFI forces tlast and stops tracing until cleared
    do_reset(); tlast_interval = 8;
    ins(64'h5000, NOP);
    chk("wfi_pre_tlast", tlast, 0);
    ins(64'h5004, WFI);
    chk("wfi_tlast", tlast, 1);
    ins_exp(64'h5008, 0, "wfi_block");
    wr(8'h04, 0);
    ins_exp(64'h500C, 1, "wfi_resume");
    step();

    // Interval shrunk mid-packet closes on the next beat
    do_reset(); tlast_interval = 8;
    for (int k = 0; k < 4; k++) ins(64'h6000 + 4*k, NOP);
    tlast_interval = 2; #1;
    chk("ivl_shrink", tlast, 1);
    step();

    // Mid-operation reset with queued entries
    do_reset(); tready = 0;
    wr(8'h00, 1); wr(8'h02, 64'h7000);
    ins(64'h7000, NOP);
    for (int k = 1; k < 5; k++) ins(64'h7000 + 4*k, NOP);
    chk("pre_rst_level", level, 5);
    rst_n = 0; step(); rst_n = 1;
    chk("mid_rst_valid", tvalid, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_tlast", tlast, 0);
    ins(64'h1234, NOP);
    chk("post_rst_default", level, 1);

    // Randomized run against the model
    tlast_interval = 3;
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      pc_valid = ($urandom_range(0, 3) != 0);
      pc = 64'h100 + 4 * $urandom_range(0, 15);
      instr = ($urandom_range(0, 23) == 0) ? WFI : $urandom;
      tready = ($urandom_range(0, 9) < 6);
      ctrl_we = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 9))
        0: ctrl_addr = 8'h00;
        1: ctrl_addr = 8'h01;
        2: ctrl_addr = 8'h02;
        3: ctrl_addr = 8'h03;
        4, 5: ctrl_addr = 8'h04;
        6: ctrl_addr = 8'h05;
        7: ctrl_addr = 8'h06;
        8: ctrl_addr = 8'h10 + 8'($urandom_range(0, 7));
        default: ctrl_addr = 8'h20;
      endcase
      if (ctrl_addr == 8'h02 || ctrl_addr == 8'h03 || ctrl_addr >= 8'h10)
        ctrl_wdata = 64'hF0 + $urandom_range(0, 95);
      else if (ctrl_addr == 8'h05)
        ctrl_wdata = $urandom_range(0, 15);
      else if (ctrl_addr == 8'h04)
        ctrl_wdata = 0;
      else
        ctrl_wdata = $urandom_range(0, 1);
      if ($urandom_range(0, 49) == 0) tlast_interval = $urandom_range(0, 5);
      step();
    end
    rst_n = 1; ctrl_we = 0; pc_valid = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
